// File: rtl/uart_pkg.sv
// Shared UART definitions, used by the receiver and the future transmitter.
//   uart_state_t : frame FSM states
//   UART_OVS     : default oversample ticks per bit
//   baud_div()   : rounded clock divider giving one oversample tick
package uart_pkg;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;

   localparam int UART_OVS = 16;

   // Rounded clk / (baud * ovs).
   function automatic int baud_div(input int clk, input int baud, input int ovs);
      return (clk + (baud * ovs) / 2) / (baud * ovs);
   endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Oversample tick generator.
//   sysclk : clock
//   reset  : synchronous active-high reset
//   clr    : synchronous clear, re-phases the divider (tick suppressed that cycle)
//   tick   : one-cycle pulse every DIV cycles, when the counter reaches DIV-1
module uart_baud_tick #(
   parameter int DIV = 326
) (
   input  logic sysclk,
   input  logic reset,
   input  logic clr,
   output logic tick
);

   localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

   logic [W-1:0] div_cnt_reg;
   logic         at_top;

   assign at_top = (div_cnt_reg == W'(DIV - 1));
   assign tick   = at_top && !clr;

   always_ff @(posedge sysclk) begin
      if (reset || clr) begin
         div_cnt_reg <= '0;
      end else if (at_top) begin
         div_cnt_reg <= '0;
      end else begin
         div_cnt_reg <= div_cnt_reg + 1'b1;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver, LSB first, OVS-times oversampled, with sticky status.
//   sysclk       : clock
//   reset        : synchronous active-high reset
//   rx           : asynchronous serial line, idles high
//   rd_ack       : one-cycle pulse, byte consumed; clears valid and both flags
//   rx_data      : last accepted byte
//   rx_valid     : byte available, held until rd_ack
//   rx_frame_err : sticky, a stop bit was sampled low
//   rx_overrun   : sticky, a complete byte was dropped while rx_valid was set
//   rx_busy      : frame in progress
module uart_receiver
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 50000000,
   parameter int BAUD     = 9600,
   parameter int OVS      = UART_OVS
) (
   input  logic       sysclk,
   input  logic       reset,
   input  logic       rx,
   input  logic       rd_ack,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_overrun,
   output logic       rx_busy
);

   localparam int DIV  = baud_div(CLK_FREQ, BAUD, OVS);
   localparam int OS_W = $clog2(OVS);

   logic              sync1_reg;
   logic              rxs_reg;
   logic              rx_prev_reg;
   uart_state_t       state_reg;
   logic [OS_W-1:0]   os_cnt_reg;
   logic [2:0]        bit_cnt_reg;
   logic [7:0]        shreg_reg;
   logic [7:0]        rx_data_reg;
   logic              rx_valid_reg;
   logic              frame_err_reg;
   logic              overrun_reg;
   logic              busy_reg;
   logic              start_det;
   logic              tick;
   logic              os_mid;
   logic              os_last;

   // Edge rather than level: a line held low (break) cannot retrigger.
   assign start_det = (state_reg == IDLE) && rx_prev_reg && !rxs_reg;
   assign os_mid    = (os_cnt_reg == OS_W'(OVS / 2 - 1));
   assign os_last   = (os_cnt_reg == OS_W'(OVS - 1));

   // Clearing on the start edge puts every sample half a bit after a boundary.
   uart_baud_tick #(
      .DIV (DIV)
   ) u_tick (
      .sysclk (sysclk),
      .reset  (reset),
      .clr    (start_det),
      .tick   (tick)
   );

   always_ff @(posedge sysclk) begin
      if (reset) begin
         sync1_reg     <= 1'b1;
         rxs_reg       <= 1'b1;
         rx_prev_reg   <= 1'b1;
         state_reg     <= IDLE;
         os_cnt_reg    <= '0;
         bit_cnt_reg   <= '0;
         shreg_reg     <= '0;
         rx_data_reg   <= '0;
         rx_valid_reg  <= 1'b0;
         frame_err_reg <= 1'b0;
         overrun_reg   <= 1'b0;
         busy_reg      <= 1'b0;
      end else begin
         sync1_reg   <= rx;
         rxs_reg     <= sync1_reg;
         rx_prev_reg <= rxs_reg;

         // Consumption clears status; events in the FSM below override it.
         if (rd_ack) begin
            rx_valid_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
         end

         case (state_reg)
            IDLE: begin
               if (start_det) begin
                  state_reg  <= START;
                  os_cnt_reg <= '0;
                  busy_reg   <= 1'b1;
               end
            end
            START: begin
               if (tick) begin
                  if (os_mid) begin
                     if (rxs_reg) begin
                        // Line back high by mid start bit: treat as a glitch.
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                     end else begin
                        state_reg   <= DATA;
                        os_cnt_reg  <= '0;
                        bit_cnt_reg <= '0;
                     end
                  end else begin
                     os_cnt_reg <= os_cnt_reg + 1'b1;
                  end
               end
            end
            DATA: begin
               if (tick) begin
                  if (os_last) begin
                     shreg_reg  <= {rxs_reg, shreg_reg[7:1]};
                     os_cnt_reg <= '0;
                     if (bit_cnt_reg == 3'd7) begin
                        state_reg <= STOP;
                     end else begin
                        bit_cnt_reg <= bit_cnt_reg + 3'd1;
                     end
                  end else begin
                     os_cnt_reg <= os_cnt_reg + 1'b1;
                  end
               end
            end
            STOP: begin
               if (tick) begin
                  if (os_last) begin
                     state_reg <= IDLE;
                     busy_reg  <= 1'b0;
                     if (rxs_reg) begin
                        // A same-cycle rd_ack frees the holding register.
                        if (!rx_valid_reg || rd_ack) begin
                           rx_data_reg  <= shreg_reg;
                           rx_valid_reg <= 1'b1;
                        end else begin
                           overrun_reg <= 1'b1;
                        end
                     end else begin
                        frame_err_reg <= 1'b1;
                     end
                  end else begin
                     os_cnt_reg <= os_cnt_reg + 1'b1;
                  end
               end
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

   assign rx_data      = rx_data_reg;
   assign rx_valid     = rx_valid_reg;
   assign rx_frame_err = frame_err_reg;
   assign rx_overrun   = overrun_reg;
   assign rx_busy      = busy_reg;

endmodule

// File: tb/tb_uart_receiver.sv
// Directed bench for uart_receiver at a reduced line rate (DIV = 5, 80 cycles/bit).
module tb_uart_receiver;

   localparam int CLK_FREQ = 8000000;
   localparam int BAUD     = 100000;
   localparam int OVS      = 16;
   localparam int DIV      = 5;
   localparam int BIT      = OVS * DIV;
   // rx falls at a negedge; synchronizer + edge detect take 3 edges, stop sample
   // lands (16*9+8)*DIV later, delivery is visible one edge after that.
   localparam int LATENCY  = 3 + (16 * 9 + 8) * DIV;

   logic       sysclk = 1'b0;
   logic       reset  = 1'b1;
   logic       rx     = 1'b1;
   logic       rd_ack = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_overrun;
   logic       rx_busy;

   int         vectors     = 0;
   int         miscompares = 0;
   logic [7:0] exp_q[$];

   uart_receiver #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .OVS      (OVS)
   ) dut (
      .sysclk       (sysclk),
      .reset        (reset),
      .rx           (rx),
      .rd_ack       (rd_ack),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .rx_frame_err (rx_frame_err),
      .rx_overrun   (rx_overrun),
      .rx_busy      (rx_busy)
   );

   always #5 sysclk = ~sysclk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Caller is always at a negedge; each bit is held for BIT cycles.
   task automatic send_frame(input logic [7:0] b, input logic stop);
      rx = 1'b0;
      repeat (BIT) @(negedge sysclk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (BIT) @(negedge sysclk);
      end
      rx = stop;
      repeat (BIT) @(negedge sysclk);
      rx = 1'b1;
   endtask

   task automatic check_delivery(input string tag);
      logic [7:0] e;
      if (exp_q.size() == 0) begin
         vectors++;
         miscompares++;
         $error("FAIL %s: scoreboard empty, observed rx_data 0x%02h", tag, rx_data);
      end else begin
         e = exp_q.pop_front();
         check({tag, "_data"}, 16'(rx_data), 16'(e));
         check({tag, "_valid"}, 16'(rx_valid), 16'h1);
      end
   endtask

   task automatic pulse_ack();
      rd_ack = 1'b1;
      @(negedge sysclk);
      rd_ack = 1'b0;
   endtask

   initial begin
      int n;
      // Reset state
      repeat (4) @(negedge sysclk);
      check("rst_data", 16'(rx_data), 16'h0);
      check("rst_valid", 16'(rx_valid), 16'h0);
      check("rst_ferr", 16'(rx_frame_err), 16'h0);
      check("rst_ovr", 16'(rx_overrun), 16'h0);
      check("rst_busy", 16'(rx_busy), 16'h0);
      reset = 1'b0;
      repeat (BIT) @(negedge sysclk);

      // 0x55 with delivery latency
      exp_q.push_back(8'h55);
      n = 0;
      fork
         send_frame(8'h55, 1'b1);
         begin
            while (rx_valid !== 1'b1 && n < 2000) begin
               @(negedge sysclk);
               n++;
            end
            check("latency_55", 16'(n), 16'(LATENCY));
         end
      join
      check_delivery("rx55");
      check("rx55_ferr", 16'(rx_frame_err), 16'h0);
      check("rx55_ovr", 16'(rx_overrun), 16'h0);
      check("rx55_busy", 16'(rx_busy), 16'h0);
      pulse_ack();
      check("ack55_valid", 16'(rx_valid), 16'h0);

      // 0xA5 then 0x3C back-to-back, ack in between
      exp_q.push_back(8'hA5);
      send_frame(8'hA5, 1'b1);
      exp_q.push_back(8'h3C);
      fork
         send_frame(8'h3C, 1'b1);
         begin
            check_delivery("rxA5");
            pulse_ack();
            check("ackA5_valid", 16'(rx_valid), 16'h0);
         end
      join
      check_delivery("rx3C");
      check("rx3C_ovr", 16'(rx_overrun), 16'h0);
      pulse_ack();

      // Overrun: 0x12 not acked, 0x34 dropped
      exp_q.push_back(8'h12);
      send_frame(8'h12, 1'b1);
      send_frame(8'h34, 1'b1);
      check_delivery("rx12");
      check("ovr_flag", 16'(rx_overrun), 16'h1);
      pulse_ack();
      check("ovr_clr_valid", 16'(rx_valid), 16'h0);
      check("ovr_clr_ovr", 16'(rx_overrun), 16'h0);
      check("ovr_clr_ferr", 16'(rx_frame_err), 16'h0);

      // Framing error on 0x81, then good 0x7E
      send_frame(8'h81, 1'b0);
      repeat (BIT) @(negedge sysclk);
      check("ferr_flag", 16'(rx_frame_err), 16'h1);
      check("ferr_valid", 16'(rx_valid), 16'h0);
      check("ferr_data", 16'(rx_data), 16'h12);
      exp_q.push_back(8'h7E);
      send_frame(8'h7E, 1'b1);
      check_delivery("rx7E");
      check("rx7E_ferr", 16'(rx_frame_err), 16'h1);
      pulse_ack();
      check("ack7E_ferr", 16'(rx_frame_err), 16'h0);
      check("ack7E_valid", 16'(rx_valid), 16'h0);

      // Glitch shorter than half a bit
      rx = 1'b0;
      repeat (20) @(negedge sysclk);
      rx = 1'b1;
      check("glitch_busy_hi", 16'(rx_busy), 16'h1);
      repeat (60) @(negedge sysclk);
      check("glitch_busy_lo", 16'(rx_busy), 16'h0);
      check("glitch_valid", 16'(rx_valid), 16'h0);
      check("glitch_ferr", 16'(rx_frame_err), 16'h0);
      check("glitch_ovr", 16'(rx_overrun), 16'h0);
      repeat (BIT) @(negedge sysclk);

      // rd_ack coincident with delivery of 0x99 while a byte is held
      exp_q.push_back(8'h11);
      send_frame(8'h11, 1'b1);
      check_delivery("rx11");
      exp_q.push_back(8'h99);
      fork
         send_frame(8'h99, 1'b1);
         begin
            repeat (LATENCY - 1) @(negedge sysclk);
            rd_ack = 1'b1;
            @(negedge sysclk);
            rd_ack = 1'b0;
         end
      join
      check_delivery("rx99");
      check("rx99_ovr", 16'(rx_overrun), 16'h0);

      // Reset during data bit 4 of 0xF0 (line high there), then clean 0x0F
      fork
         send_frame(8'hF0, 1'b1);
         begin
            repeat (450) @(negedge sysclk);
            reset = 1'b1;
            @(negedge sysclk);
            check("mrst_data", 16'(rx_data), 16'h0);
            check("mrst_valid", 16'(rx_valid), 16'h0);
            check("mrst_busy", 16'(rx_busy), 16'h0);
            check("mrst_ferr", 16'(rx_frame_err), 16'h0);
            check("mrst_ovr", 16'(rx_overrun), 16'h0);
            reset = 1'b0;
         end
      join
      repeat (BIT) @(negedge sysclk);
      exp_q.push_back(8'h0F);
      send_frame(8'h0F, 1'b1);
      check_delivery("rx0F");
      check("rx0F_ferr", 16'(rx_frame_err), 16'h0);
      check("rx0F_ovr", 16'(rx_overrun), 16'h0);
      check("rx0F_busy", 16'(rx_busy), 16'h0);
      check("sb_empty", 16'(exp_q.size()), 16'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
